hazard_unit_sb: RTL and testbench

- Parametrised successor to the single-cycle load-use/branch hazard unit of the 5-stage RISC-V pipeline.
- Tracks outstanding long-latency writes (multi-cycle load, mul/div) in a per-register scoreboard.
- Stalls IF/ID on RAW hazards against pending writers, or when the in-flight limit is reached.
- Generates IF/ID and ID/EX flushes on branch mispredict or jump, with defined priority over stalls.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_scoreboard.sv | 68 ++++++
 rtl/hazard_unit_sb.sv | 109 ++++++++++
 tb/tb_hazard_unit_sb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboarded hazard unit.
//   NREG_DEF / REG_W_DEF : default register-file geometry
//   PERF_W               : width of the optional performance counters
//   flush_cause_t        : reason an EX-stage redirect flushes the front end
package hazard_pkg;

  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned PERF_W    = 32;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    MISPRED = 2'd1,
    JUMP    = 2'd2
  } flush_cause_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard for outstanding long-latency writers.
//   clk, rst          : clock, synchronous active-high reset
//   rs1, rs2          : source registers to look up
//   set_en, set_rd    : issue of a long-latency writer to set_rd
//   wb_valid, wb_rd   : long-latency writeback clearing wb_rd
//   busy1, busy2      : lookup result for rs1 / rs2
//   full              : pend_cnt has reached MAX_PEND
//   pend_cnt          : number of outstanding writers
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG      = NREG_DEF,
  parameter int unsigned REG_W     = REG_W_DEF,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REG_W-1:0]                  rs1,
  input  logic [REG_W-1:0]                  rs2,
  input  logic                              set_en,
  input  logic [REG_W-1:0]                  set_rd,
  input  logic                              wb_valid,
  input  logic [REG_W-1:0]                  wb_rd,
  output logic                              busy1,
  output logic                              busy2,
  output logic                              full,
  output logic [$clog2(MAX_PEND+1)-1:0]     pend_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  logic [NREG-1:0] sb;
  logic            set_ok;
  logic            clr_ok;

  // x0 never becomes busy; a writeback to an idle register is ignored.
  assign set_ok = set_en && (set_rd != '0);
  assign clr_ok = wb_valid && sb[wb_rd] && (pend_cnt != '0);
  assign full   = (pend_cnt == CNT_W'(MAX_PEND));

  always_comb begin
    busy1 = sb[rs1];
    busy2 = sb[rs2];
    if (WB_BYPASS != 0) begin
      if (wb_valid && (wb_rd == rs1)) busy1 = 1'b0;
      if (wb_valid && (wb_rd == rs2)) busy2 = 1'b0;
    end
  end

  // Set is applied after clear so a same-register collision keeps the
  // newer writer busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb       <= '0;
      pend_cnt <= '0;
    end else begin
      if (clr_ok) sb[wb_rd]  <= 1'b0;
      if (set_ok) sb[set_rd] <= 1'b1;
      case ({set_ok, clr_ok})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// Scoreboarded hazard unit for the 5-stage pipeline: stalls IF/ID on RAW
// hazards against outstanding long-latency writers (or when MAX_PEND writers
// are in flight) and flushes IF/ID, ID/EX on mispredict or jump. A redirect
// overrides any stall so the PC can load its target.
// Optional: define HAZARD_PERF_EN to add stall_cycles / flush_events
// saturating counters.
//   id_*      : ID-stage instruction fields
//   wb_*      : long-latency writeback
//   ex_*      : EX-stage branch/jump resolution
//   f_stall, d_stall, d_flush, e_flush : pipeline control (0 during rst)
//   pend_cnt  : outstanding long-latency writers
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NREG      = NREG_DEF,
  parameter int unsigned REG_W     = REG_W_DEF,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_W-1:0]              id_rs1,
  input  logic [REG_W-1:0]              id_rs2,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic [REG_W-1:0]              id_rd,
  input  logic                          id_valid,
  input  logic                          id_long,
  input  logic                          wb_valid,
  input  logic [REG_W-1:0]              wb_rd,
  input  logic                          ex_valid,
  input  logic                          ex_branch,
  input  logic                          ex_pred,
  input  logic                          ex_jump,
  output logic                          f_stall,
  output logic                          d_stall,
  output logic                          d_flush,
  output logic                          e_flush,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]             stall_cycles,
  output logic [PERF_W-1:0]             flush_events
`endif
);

  flush_cause_t cause;
  logic         redirect;
  logic         haz;
  logic         issue;
  logic         busy1;
  logic         busy2;
  logic         full;

  always_comb begin
    cause = NONE;
    if (ex_valid) begin
      if (ex_jump)                 cause = JUMP;
      else if (ex_branch ^ ex_pred) cause = MISPRED;
    end
  end

  assign redirect = (cause != NONE);

  assign haz = id_valid &&
               ((id_rs1_used && (id_rs1 != '0) && busy1) ||
                (id_rs2_used && (id_rs2 != '0) && busy2) ||
                (id_long && full));

  assign issue = id_valid && !haz && !redirect;

  assign f_stall = !rst && haz && !redirect;
  assign d_stall = f_stall;
  assign d_flush = !rst && redirect;
  assign e_flush = !rst && (redirect || haz);

  hazard_scoreboard #(
    .NREG      (NREG),
    .REG_W     (REG_W),
    .MAX_PEND  (MAX_PEND),
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .set_en   (issue && id_long),
    .set_rd   (id_rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .busy1    (busy1),
    .busy2    (busy2),
    .full     (full),
    .pend_cnt (pend_cnt)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (f_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
      if (redirect && (flush_events != '1)) flush_events <= flush_events + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb (default parameters: MAX_PEND=4,
// WB_BYPASS=1). Expected control/count values are queued when a step is
// driven and compared mid-cycle, before the next rising edge.
module tb_hazard_unit_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, id_valid, id_long;
  logic       wb_valid, ex_valid, ex_branch, ex_pred, ex_jump;
  logic       f_stall, d_stall, d_flush, e_flush;
  logic [2:0] pend_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  typedef struct packed {
    logic [3:0] ctl;  // {f_stall, d_stall, d_flush, e_flush}
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hazard_unit_sb dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_valid    (id_valid),
    .id_long     (id_long),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_pred     (ex_pred),
    .ex_jump     (ex_jump),
    .f_stall     (f_stall),
    .d_stall     (d_stall),
    .d_flush     (d_flush),
    .e_flush     (e_flush),
    .pend_cnt    (pend_cnt)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  task automatic idle();
    id_valid = 0; id_long = 0; id_rd = 0;
    id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    wb_valid = 0; wb_rd = 0;
    ex_valid = 0; ex_branch = 0; ex_pred = 0; ex_jump = 0;
  endtask

  task automatic set_id(input logic lng, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    id_valid = 1; id_long = lng; id_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  task automatic set_wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  task automatic set_ex(input logic br, input logic pr, input logic jmp);
    ex_valid = 1; ex_branch = br; ex_pred = pr; ex_jump = jmp;
  endtask

  // Inputs are already driven (at the falling edge); sample 2 ns later,
  // then advance to the next falling edge past the rising edge.
  task automatic check(input string tag, input logic [3:0] ectl, input logic [2:0] ecnt);
    exp_t e;
    exp_q.push_back('{ctl: ectl, cnt: ecnt});
    #2;
    e = exp_q.pop_front();
    n_checks++;
    assert ({f_stall, d_stall, d_flush, e_flush} === e.ctl) n_pass++;
    else $error("FAIL %s ctl observed=%b expected=%b", tag,
                {f_stall, d_stall, d_flush, e_flush}, e.ctl);
    n_checks++;
    assert (pend_cnt === e.cnt) n_pass++;
    else $error("FAIL %s pend_cnt observed=%0d expected=%0d", tag, pend_cnt, e.cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; idle();
    @(negedge clk);
    // reset held with hazard and redirect stimulus present
    set_id(1, 3, 0, 0, 0, 0); set_ex(0, 0, 1);
    check("rst_hold", 4'b0000, 0);
    rst = 0; idle();
    check("idle", 4'b0000, 0);

    // load-use: long op to x5, consumer stalls 3 cycles, released in wb cycle
    idle(); set_id(1, 5, 0, 0, 0, 0);   check("lu_issue", 4'b0000, 0);
    idle(); set_id(0, 0, 5, 1, 0, 0);   check("lu_stall1", 4'b1101, 1);
    check("lu_stall2", 4'b1101, 1);
    check("lu_stall3", 4'b1101, 1);
    set_wb(5);                          check("lu_wb_bypass", 4'b0000, 1);
    idle();                             check("lu_after", 4'b0000, 0);

    // cap: four writers fill the scoreboard, a fifth waits for any wb
    for (int unsigned r = 1; r <= 4; r++) begin
      idle(); set_id(1, 5'(r), 0, 0, 0, 0);
      check("cap_fill", 4'b0000, 3'(r - 1));
    end
    idle(); set_id(1, 6, 0, 0, 0, 0);   check("cap_stall", 4'b1101, 4);
    set_wb(2);                          check("cap_stall_wb", 4'b1101, 4);
    idle(); set_id(1, 6, 0, 0, 0, 0);   check("cap_issue", 4'b0000, 3);
    idle();                             check("cap_refull", 4'b0000, 4);

    // mispredict while hazarded: flush wins, no bit set for x9
    idle(); set_id(1, 9, 1, 1, 0, 0); set_ex(1, 0, 0);
    check("mp_stall", 4'b0011, 4);
    idle(); set_id(0, 0, 9, 1, 0, 0);   check("mp_noset", 4'b0000, 4);
    idle(); set_ex(0, 0, 1);            check("jump", 4'b0011, 4);
    idle(); set_id(0, 0, 0, 0, 3, 1); set_ex(1, 1, 0);
    check("pred_ok_rs2", 4'b1101, 4);
    idle(); ex_branch = 1;              check("ex_invalid", 4'b0000, 4);

    // drain
    idle(); set_wb(1);                  check("drain1", 4'b0000, 4);
    idle(); set_wb(3);                  check("drain3", 4'b0000, 3);
    idle(); set_wb(4);                  check("drain4", 4'b0000, 2);
    idle(); set_wb(6);                  check("drain6", 4'b0000, 1);
    idle(); set_wb(12);                 check("wb_spurious", 4'b0000, 0);
    idle();                             check("wb_spur_after", 4'b0000, 0);

    // same-cycle set and clear of x7: set wins, count unchanged
    idle(); set_id(1, 7, 0, 0, 0, 0);   check("sc_first", 4'b0000, 0);
    idle(); set_id(1, 7, 0, 0, 0, 0); set_wb(7);
    check("sc_both", 4'b0000, 1);
    idle(); set_id(0, 0, 7, 1, 0, 0);   check("sc_busy", 4'b1101, 1);
    set_wb(7);                          check("sc_wb", 4'b0000, 1);
    idle();                             check("sc_empty", 4'b0000, 0);

    // x0 is never tracked
    idle(); set_id(1, 0, 0, 0, 0, 0);   check("x0_long", 4'b0000, 0);
    idle(); set_id(0, 0, 0, 1, 0, 1);   check("x0_use", 4'b0000, 0);

    // reset mid-flight
    for (int unsigned r = 10; r <= 12; r++) begin
      idle(); set_id(1, 5'(r), 0, 0, 0, 0);
      check("rm_fill", 4'b0000, 3'(r - 10));
    end
    idle(); rst = 1; set_id(0, 0, 10, 1, 0, 0); set_ex(0, 0, 1);
    check("rm_rst", 4'b0000, 3);
    rst = 0; idle(); set_id(0, 0, 10, 1, 0, 0);
    check("rm_cleared", 4'b0000, 0);
    idle(); set_ex(0, 1, 0);            check("mp_nottaken", 4'b0011, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
